// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO controller around an external 1R1W SRAM.
// The SRAM's registered read is hidden behind a 2-entry prefetch buffer so
// one push and one pop per cycle are sustained. Total capacity DEPTH+2.
// Optional build macro SRAM_FIFO_STATS_EN adds simulation-only statistics
// counters (printed at end of simulation) and internal sanity assertions.
module sram_fifo_ctrl #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int DEPTH       = 16,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int COUNT_WIDTH = $clog2(DEPTH + 3)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   sram_wr,
    output logic [ADDR_WIDTH-1:0]  sram_wr_addr,
    output logic [DATA_WIDTH-1:0]  sram_wr_din,
    output logic                   sram_rd,
    output logic [ADDR_WIDTH-1:0]  sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]  sram_rd_dout,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [ADDR_WIDTH:0] SRAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_sram_cnt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_obuf [2];
    logic [1:0]            r_ob_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd;
    logic [1:0]            w_slot;
    logic [1:0]            w_pending;

    // Handshakes, read issue and capture slot; w_pending (buffer + in-flight
    // after this cycle's pop) never exceeds 2 because a read is only issued
    // while it is below 2.
    always_comb begin
        in_ready  = (r_sram_cnt < SRAM_FULL);
        w_push    = in_valid & in_ready;
        out_valid = (r_ob_cnt != 2'd0);
        out_data  = r_obuf[0];
        w_pop     = out_valid & out_ready;
        w_slot    = r_ob_cnt - {1'b0, w_pop};
        w_pending = w_slot + {1'b0, r_inflight};
        w_rd      = (r_sram_cnt != '0) && (w_pending < 2'd2);
    end

    assign sram_wr      = w_push;
    assign sram_wr_addr = r_wr_ptr;
    assign sram_wr_din  = in_data;
    assign sram_rd      = w_rd;
    assign sram_rd_addr = r_rd_ptr;
    assign count        = COUNT_WIDTH'(r_sram_cnt) + COUNT_WIDTH'(r_inflight)
                        + COUNT_WIDTH'(r_ob_cnt);

    // Pointers, SRAM occupancy and in-flight read tracking.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_sram_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_sram_cnt <= r_sram_cnt + (ADDR_WIDTH + 1)'(w_push)
                                     - (ADDR_WIDTH + 1)'(w_rd);
            r_inflight <= w_rd;
        end
    end

    // Prefetch buffer: shift on pop, then land returning read data in the
    // first free slot after the shift (later assignment wins on overlap).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_obuf[0] <= '0;
            r_obuf[1] <= '0;
            r_ob_cnt  <= '0;
        end else begin
            if (w_pop) r_obuf[0] <= r_obuf[1];
            if (r_inflight) begin
                if (w_slot == 2'd0) r_obuf[0] <= sram_rd_dout;
                else                r_obuf[1] <= sram_rd_dout;
            end
            r_ob_cnt <= w_pending;
        end
    end

`ifdef SRAM_FIFO_STATS_EN
    logic [31:0]            r_push_cnt;
    logic [31:0]            r_pop_cnt;
    logic [31:0]            r_full_stall;
    logic [COUNT_WIDTH-1:0] r_peak;

    // Statistics counters and internal consistency checks.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_push_cnt   <= '0;
            r_pop_cnt    <= '0;
            r_full_stall <= '0;
            r_peak       <= '0;
        end else begin
            if (w_push)               r_push_cnt   <= r_push_cnt + 1;
            if (w_pop)                r_pop_cnt    <= r_pop_cnt + 1;
            if (in_valid & ~in_ready) r_full_stall <= r_full_stall + 1;
            if (count > r_peak)       r_peak       <= count;
            assert (!(r_inflight && (w_slot == 2'd2)))
                else $error("[%m] capture into a full prefetch buffer");
            assert (r_sram_cnt <= SRAM_FULL)
                else $error("[%m] sram_cnt exceeds DEPTH");
        end
    end

    final begin
        $display("[%m] push_cnt: %1d", r_push_cnt);
        $display("[%m] pop_cnt: %1d", r_pop_cnt);
        $display("[%m] peak_count: %1d", r_peak);
        $display("[%m] full_stall_cycles: %1d", r_full_stall);
    end
`else
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1R1W SRAM model.
module tb_sram_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          sram_wr;
    logic [AW-1:0] sram_wr_addr;
    logic [DW-1:0] sram_wr_din;
    logic          sram_rd;
    logic [AW-1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_dout = '0;
    logic [CW-1:0] count;

    logic [DW-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int npush   = 0;
    int npop    = 0;
    logic did_pop;
    logic [DW-1:0] q[$];

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sram_wr(sram_wr), .sram_wr_addr(sram_wr_addr), .sram_wr_din(sram_wr_din),
        .sram_rd(sram_rd), .sram_rd_addr(sram_rd_addr), .sram_rd_dout(sram_rd_dout),
        .count(count)
    );

    always #5 clk = ~clk;

    // 1R1W SRAM with registered read
    always @(posedge clk) begin
        if (sram_wr) mem[sram_wr_addr] <= sram_wr_din;
        if (sram_rd) sram_rd_dout <= mem[sram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply reset, check reset outputs, release.
    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sram_wr", sram_wr, 0);
        check("rst_sram_rd", sram_rd, 0);
        check("rst_count", count, 0);
        q.delete(); npush = 0; npop = 0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    // One cycle: check occupancy, drive inputs, score handshakes that the
    // next rising edge will perform.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
        @(negedge clk);
        check("count", count, npush - npop);
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        did_pop = 1'b0;
        if (in_valid && in_ready) begin
            check("wr_en", sram_wr, 1);
            check("wr_addr", sram_wr_addr, npush % DEPTH);
            check("wr_din", sram_wr_din, id);
            q.push_back(id);
            npush++;
        end else begin
            check("no_wr", sram_wr, 0);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("underflow", q.size(), 1);
            else check("out_data", out_data, q.pop_front());
            npop++;
            did_pop = 1'b1;
        end
    endtask

    initial begin
        int cyc;
        int bubbles;
        int first_pop;

        // --- single push latency ---
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t1_rd", sram_rd, 1);
        check("t1_rd_addr", sram_rd_addr, 0);
        check("t1_ov_n1", out_valid, 0);
        step(1'b0, 8'h00, 1'b0);
        check("t1_ov_n2", out_valid, 0);
        check("t1_rd_idle", sram_rd, 0);
        step(1'b0, 8'h00, 1'b1);
        check("t1_ov", out_valid, 1);
        check("t1_data", out_data, 8'hA5);
        step(1'b0, 8'h00, 1'b0);
        check("t1_ov_after", out_valid, 0);
        check("t1_count0", count, 0);

        // --- fill to DEPTH+2 with no pops, then drain ---
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("full_count", count, 18);
        check("full_in_ready", in_ready, 0);
        step(1'b1, 8'h77, 1'b0);
        check("full_no_wr", sram_wr, 0);
        cyc = 0;
        while (q.size() != 0 && cyc < 60) begin
            step(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        check("full_drained", npop, 18);
        step(1'b0, 8'h00, 1'b0);

        // --- streaming 0..99, no bubbles ---
        do_reset();
        cyc = 0; bubbles = 0; first_pop = -1;
        while (npop < 100 && cyc < 300) begin
            step(npush < 100, 8'(npush), 1'b1);
            if (did_pop && first_pop < 0) first_pop = cyc;
            else if (npop > 0 && !did_pop && npop < 100) bubbles++;
            cyc++;
        end
        check("stream_done", npop, 100);
        check("stream_first", first_pop, 3);
        check("stream_bubbles", bubbles, 0);

        // --- random handshakes, 1000 items ---
        do_reset();
        cyc = 0;
        while (npop < 1000 && cyc < 20000) begin
            step((npush < 1000) && ($urandom_range(0, 1) == 1), 8'($urandom),
                 $urandom_range(0, 1) == 1);
            cyc++;
        end
        check("rand_done", npop, 1000);

        // --- reset with a read in flight ---
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h06, 1'b1);
        @(negedge clk);
        check("mid_count_pre", count, 5);
        check("mid_rd_addr", sram_rd_addr, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        arst = 1'b1;
        #1;
        check("mid_count", count, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_sram_rd", sram_rd, 0);
        q.delete(); npush = 0; npop = 0;
        @(negedge clk);
        arst = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        cyc = 0;
        while (npop < 1 && cyc < 10) begin
            step(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        check("mid_first_out", npop, 1);
        step(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
